// File: rtl/opb_master_cmd_initiator.sv
// opb_master_cmd_initiator
//   Single-beat OPB bus master. Accepts one read/write command at a time on a
//   valid/ready port, arbitrates for the bus, runs the transfer (handling slave
//   retry and bus timeout) and returns read data plus a completion status.
//   Optional feature macro: OPB_MASTER_BUSLOCK_EN (hold M_busLock from grant
//   through retries until the command terminates).
module opb_master_cmd_initiator #(
    parameter int C_OPB_AWIDTH     = 32,
    parameter int C_OPB_DWIDTH     = 32,
    parameter int C_TIMEOUT_CYCLES = 16,
    parameter int C_MAX_RETRY      = 3,
    parameter     C_FAMILY         = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    output logic                    M_request,
    input  logic                    OPB_MGrant,
    output logic                    M_select,
    output logic [0:C_OPB_AWIDTH-1] M_ABus,
    output logic [0:3]              M_BE,
    output logic [0:C_OPB_DWIDTH-1] M_DBus,
    output logic                    M_RNW,
    output logic                    M_seqAddr,
    output logic                    M_busLock,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_xferAck,
    input  logic                    OPB_errAck,
    input  logic                    OPB_retry,
    input  logic                    OPB_toutSup,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rnw,
    input  logic [C_OPB_AWIDTH-1:0] cmd_addr,
    input  logic [3:0]              cmd_be,
    input  logic [C_OPB_DWIDTH-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [C_OPB_DWIDTH-1:0] rsp_rdata,
    output logic [1:0]              rsp_status
);

    if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 ||
        C_TIMEOUT_CYCLES < 2 || C_TIMEOUT_CYCLES > 255 ||
        C_MAX_RETRY < 0 || C_MAX_RETRY > 15 || $bits(C_FAMILY) < 8) begin : g_bad_params
        $error("opb_master_cmd_initiator: parameter out of range");
    end

    localparam logic [1:0] STATUS_OK         = 2'b00;
    localparam logic [1:0] STATUS_ERR        = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT    = 2'b10;
    localparam logic [1:0] STATUS_RETRY_FAIL = 2'b11;

    localparam logic [7:0] TOUT_LIMIT  = 8'(C_TIMEOUT_CYCLES);
    localparam logic [3:0] RETRY_LIMIT = 4'(C_MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        BACKOFF,
        RSP
    } state_t;

    state_t                  state;
    logic                    cmd_rnw_q;
    logic [C_OPB_AWIDTH-1:0] cmd_addr_q;
    logic [3:0]              cmd_be_q;
    logic [C_OPB_DWIDTH-1:0] cmd_wdata_q;
    logic [7:0]              tout_cnt;
    logic [3:0]              retry_cnt;

    logic [7:0]              tout_next;
    logic                    term;
    logic                    do_backoff;
    logic [1:0]              term_status;
    logic [C_OPB_DWIDTH-1:0] term_rdata;

    assign M_seqAddr = 1'b0;

    // Decode the slave response for the current select cycle (ack > retry > timeout)
    always_comb begin
        tout_next   = tout_cnt;
        term        = 1'b0;
        do_backoff  = 1'b0;
        term_status = STATUS_OK;
        term_rdata  = '0;
        if (!OPB_toutSup && tout_cnt != '1) begin
            tout_next = tout_cnt + 8'd1;
        end
        if (OPB_xferAck || OPB_errAck) begin
            term = 1'b1;
            if (OPB_errAck) begin
                term_status = STATUS_ERR;
            end else if (cmd_rnw_q) begin
                term_rdata = OPB_DBus;
            end
        end else if (OPB_retry) begin
            if (retry_cnt < RETRY_LIMIT) begin
                do_backoff = 1'b1;
            end else begin
                term        = 1'b1;
                term_status = STATUS_RETRY_FAIL;
            end
        end else if (tout_next >= TOUT_LIMIT) begin
            term        = 1'b1;
            term_status = STATUS_TIMEOUT;
        end
    end

    // Command FSM with registered bus and response outputs
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            M_request   <= 1'b0;
            M_select    <= 1'b0;
            M_ABus      <= '0;
            M_BE        <= '0;
            M_DBus      <= '0;
            M_RNW       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= STATUS_OK;
            cmd_rnw_q   <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_be_q    <= '0;
            cmd_wdata_q <= '0;
            tout_cnt    <= '0;
            retry_cnt   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_rnw_q   <= cmd_rnw;
                        cmd_addr_q  <= cmd_addr;
                        cmd_be_q    <= cmd_be;
                        cmd_wdata_q <= cmd_wdata;
                        retry_cnt   <= '0;
                        cmd_ready   <= 1'b0;
                        M_request   <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (OPB_MGrant) begin
                        M_request <= 1'b0;
                        M_select  <= 1'b1;
                        M_ABus    <= cmd_addr_q;
                        M_BE      <= cmd_be_q;
                        M_DBus    <= cmd_wdata_q;
                        M_RNW     <= cmd_rnw_q;
                        tout_cnt  <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    tout_cnt <= tout_next;
                    // bus drivers drop together with select so the OR-bus sees zeros
                    if (term || do_backoff) begin
                        M_select <= 1'b0;
                        M_ABus   <= '0;
                        M_BE     <= '0;
                        M_DBus   <= '0;
                        M_RNW    <= 1'b0;
                    end
                    if (term) begin
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= term_rdata;
                        rsp_status <= term_status;
                        state      <= RSP;
                    end else if (do_backoff) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        state     <= BACKOFF;
                    end
                end
                BACKOFF: begin
                    M_request <= 1'b1;
                    state     <= REQ;
                end
                RSP: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef OPB_MASTER_BUSLOCK_EN
    // Bus lock held from the first grant through retries until termination
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            M_busLock <= 1'b0;
        end else if (state == REQ && OPB_MGrant) begin
            M_busLock <= 1'b1;
        end else if (state == XFER && term) begin
            M_busLock <= 1'b0;
        end
    end
`else
    assign M_busLock = 1'b0;
`endif

endmodule

// File: tb/tb_opb_master_cmd_initiator.sv
// tb_opb_master_cmd_initiator
//   Self-checking bench: the bench plays arbiter and slave from a per-command
//   script of phases, and a transaction-level model predicts status, read data,
//   select-phase lengths, latency and the backoff gap.
`timescale 1ns/1ps
module tb_opb_master_cmd_initiator;

    localparam int TOUT = 16;
    localparam int MAXR = 3;

    localparam int K_ACK      = 0;
    localparam int K_ERR      = 1;
    localparam int K_ERRACK   = 2;
    localparam int K_RETRY    = 3;
    localparam int K_RETRYACK = 4;
    localparam int K_NONE     = 5;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst = 1'b1;
    logic        M_request, M_select, M_RNW, M_seqAddr, M_busLock;
    logic        OPB_MGrant = 1'b0;
    logic [0:31] M_ABus, M_DBus;
    logic [0:3]  M_BE;
    logic [0:31] OPB_DBus = '0;
    logic        OPB_xferAck = 1'b0, OPB_errAck = 1'b0, OPB_retry = 1'b0, OPB_toutSup = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    opb_master_cmd_initiator #(
        .C_OPB_AWIDTH(32),
        .C_OPB_DWIDTH(32),
        .C_TIMEOUT_CYCLES(TOUT),
        .C_MAX_RETRY(MAXR)
    ) dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
        .M_request(M_request), .OPB_MGrant(OPB_MGrant),
        .M_select(M_select), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
        .M_RNW(M_RNW), .M_seqAddr(M_seqAddr), .M_busLock(M_busLock),
        .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
        .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // slave/arbiter script: one entry per select phase
    int sc_kind[8], sc_d[8], sc_sup[8], sc_g[8];
    int sc_n;

    // model predictions
    int          exp_nph, exp_lat;
    int          exp_len[8];
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_phase(input int i, input int k, input int d, input int s, input int g);
        sc_kind[i] = k; sc_d[i] = d; sc_sup[i] = s; sc_g[i] = g;
    endtask

    task automatic gen_script();
        sc_n = 0;
        for (int i = 0; i < 8; i++) begin
            int r, k;
            r = int'($urandom_range(0, 9));
            k = (r <= 2) ? K_ACK : (r == 3) ? K_ERR : (r == 4) ? K_ERRACK :
                (r <= 7) ? K_RETRY : (r == 8) ? K_RETRYACK : K_NONE;
            if (i == 7 && k == K_RETRY) k = K_ACK;
            sc_kind[i] = k;
            sc_g[i]    = int'($urandom_range(0, 3));
            if (k == K_NONE) begin
                sc_d[i]   = 0;
                sc_sup[i] = int'($urandom_range(0, 12));
            end else begin
                sc_d[i]   = int'($urandom_range(0, 15));
                sc_sup[i] = int'($urandom_range(0, sc_d[i]));
            end
            sc_n = i + 1;
            if (k != K_RETRY) break;
        end
    endtask

    // Transaction-level prediction from the bus rules
    task automatic model_expect(input logic rnw, input logic [31:0] sdata);
        int retries;
        retries    = 0;
        exp_nph    = 0;
        exp_lat    = 0;
        exp_status = 2'b00;
        exp_rdata  = '0;
        for (int i = 0; i < sc_n; i++) begin
            int len;
            len = (sc_kind[i] == K_NONE) ? TOUT + sc_sup[i] : sc_d[i] + 1;
            exp_len[i] = len;
            exp_lat   += 1 + sc_g[i] + len;
            exp_nph++;
            if (sc_kind[i] == K_RETRY) begin
                if (retries < MAXR) begin
                    retries++;
                    exp_lat += 1;
                    continue;
                end
                exp_status = 2'b11;
                break;
            end
            case (sc_kind[i])
                K_ACK, K_RETRYACK: begin
                    exp_status = 2'b00;
                    exp_rdata  = rnw ? sdata : 32'h0;
                end
                K_ERR, K_ERRACK: exp_status = 2'b01;
                default:         exp_status = 2'b10;
            endcase
            break;
        end
    endtask

    task automatic clear_slave();
        OPB_MGrant  = 1'b0;
        OPB_xferAck = 1'b0;
        OPB_errAck  = 1'b0;
        OPB_retry   = 1'b0;
        OPB_toutSup = 1'b0;
        OPB_DBus    = $urandom;
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge OPB_Clk); #1;
            guard++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_cmd(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [31:0] sdata);
        int  obs_len[8];
        int  ph, c, gcnt, edges, gap;
        bit  in_sel, done, want_gap, lock_exp;
        logic [1:0]  held_status;
        logic [31:0] held_rdata;

        model_expect(rnw, sdata);
        wait_ready();
        cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_wdata = wdata;
        @(posedge OPB_Clk); #1;
        // scramble the command inputs: the master must use its latched copy
        cmd_valid = 1'b0; cmd_rnw = ~rnw; cmd_addr = $urandom; cmd_be = 4'($urandom); cmd_wdata = $urandom;
        chk("accept_ready_low", 32'(cmd_ready), 32'd0);

        ph = 0; c = 0; gcnt = sc_g[0]; edges = 0; gap = 0;
        in_sel = 0; done = 0; want_gap = 0; lock_exp = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            clear_slave();
            if (!M_select && in_sel) begin
                if (ph < 8) obs_len[ph] = c;
                ph++;
                in_sel = 0;
                if (ph < 8) gcnt = sc_g[ph];
                if (!rsp_valid) begin
                    want_gap = 1;
                    gap = 0;
                end
            end
            if (rsp_valid) begin
                lock_exp = 0;
                done = 1;
                chk("rsp_status", 32'(rsp_status), 32'(exp_status));
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("latency", 32'(edges), 32'(exp_lat));
                chk("phase_count", 32'(ph), 32'(exp_nph));
                for (int i = 0; i < exp_nph && i < ph && i < 8; i++)
                    chk($sformatf("phase%0d_len", i), 32'(obs_len[i]), 32'(exp_len[i]));
            end else if (M_select) begin
                int p;
                if (!in_sel) begin
                    in_sel = 1;
                    c = 0;
                    lock_exp = 1;
                end
                c++;
                chk("sel_abus", M_ABus, addr);
                chk("sel_be", 32'(M_BE), 32'(be));
                chk("sel_rnw", 32'(M_RNW), 32'(rnw));
                if (!rnw) chk("sel_dbus", M_DBus, wdata);
                chk("sel_no_request", 32'(M_request), 32'd0);
                p = (ph < 8) ? ph : 7;
                if (sc_kind[p] == K_NONE || c <= sc_d[p]) begin
                    OPB_toutSup = (c <= sc_sup[p]);
                end else if (c == sc_d[p] + 1) begin
                    case (sc_kind[p])
                        K_ACK:      begin OPB_xferAck = 1'b1; OPB_DBus = sdata; end
                        K_ERR:      begin OPB_errAck = 1'b1;  OPB_DBus = sdata; end
                        K_ERRACK:   begin OPB_errAck = 1'b1; OPB_xferAck = 1'b1; OPB_DBus = sdata; end
                        K_RETRY:    OPB_retry = 1'b1;
                        default:    begin OPB_retry = 1'b1; OPB_xferAck = 1'b1; OPB_DBus = sdata; end
                    endcase
                end
            end else begin
                chk("idle_abus", M_ABus, 32'h0);
                chk("idle_be", 32'(M_BE), 32'h0);
                chk("idle_dbus", M_DBus, 32'h0);
                chk("idle_rnw", 32'(M_RNW), 32'h0);
                if (want_gap) begin
                    if (M_request) begin
                        chk("backoff_gap", 32'(gap), 32'd1);
                        want_gap = 0;
                    end else begin
                        gap++;
                    end
                end
                if (M_request) begin
                    if (gcnt == 0) OPB_MGrant = 1'b1;
                    else gcnt--;
                end
            end
            if (!done) chk("busy_ready_low", 32'(cmd_ready), 32'd0);
`ifdef OPB_MASTER_BUSLOCK_EN
            chk("bus_lock", 32'(M_busLock), 32'(lock_exp));
`else
            chk("bus_lock", 32'(M_busLock), 32'(1'b0 & lock_exp));
`endif
            if (!done) begin
                @(posedge OPB_Clk); #1;
                edges++;
            end
        end
        if (!done) begin
            chk("rsp_timeout", 32'd0, 32'd1);
        end else begin
            held_status = rsp_status;
            held_rdata  = rsp_rdata;
            clear_slave();
            @(posedge OPB_Clk); #1;
            chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
            chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
            chk("status_held", 32'(rsp_status), 32'(exp_status));
            chk("rdata_held", rsp_rdata, exp_rdata);
            if (held_status !== rsp_status || held_rdata !== rsp_rdata)
                chk("rsp_hold_stable", 32'd0, 32'd1);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_request"}, 32'(M_request), 32'd0);
        chk({pfx, "_select"}, 32'(M_select), 32'd0);
        chk({pfx, "_abus"}, M_ABus, 32'h0);
        chk({pfx, "_be"}, 32'(M_BE), 32'h0);
        chk({pfx, "_dbus"}, M_DBus, 32'h0);
        chk({pfx, "_rnw"}, 32'(M_RNW), 32'd0);
        chk({pfx, "_seqaddr"}, 32'(M_seqAddr), 32'd0);
        chk({pfx, "_buslock"}, 32'(M_busLock), 32'd0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({pfx, "_rsp_status"}, 32'(rsp_status), 32'd0);
        chk({pfx, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic reset_mid_xfer();
        bit seen;
        wait_ready();
        cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = 32'h0000_1234; cmd_be = 4'hF; cmd_wdata = '0;
        @(posedge OPB_Clk); #1;
        cmd_valid = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            clear_slave();
            if (M_select) begin
                seen = 1;
            end else begin
                if (M_request) OPB_MGrant = 1'b1;
                @(posedge OPB_Clk); #1;
            end
        end
        chk("rst_reached_xfer", 32'(seen), 32'd1);
        OPB_Rst = 1'b1;
        clear_slave();
        @(posedge OPB_Clk); #1;
        OPB_Rst = 1'b0;
        chk_reset_outputs("midrst");
        for (int i = 0; i < 4; i++) begin
            @(posedge OPB_Clk); #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
            chk("midrst_no_select", 32'(M_select), 32'd0);
        end
    endtask

    initial begin
        OPB_Rst = 1'b1;
        clear_slave();
        repeat (2) @(posedge OPB_Clk);
        #1;
        chk_reset_outputs("reset");
        OPB_Rst = 1'b0;

        // write, immediate grant, ack on first select cycle
        set_phase(0, K_ACK, 0, 0, 0); sc_n = 1;
        run_cmd(1'b0, 32'h0118_8000, 4'hF, 32'hDEAD_BEEF, 32'h5555_AAAA);
        // read, ack after three select cycles
        set_phase(0, K_ACK, 2, 0, 0); sc_n = 1;
        run_cmd(1'b1, 32'h0118_8004, 4'hF, 32'h0, 32'h1234_5678);
        // read with errAck and xferAck together
        set_phase(0, K_ERRACK, 1, 0, 1); sc_n = 1;
        run_cmd(1'b1, 32'h0118_8008, 4'h3, 32'h0, 32'hCAFE_F00D);
        // two retries then ack
        set_phase(0, K_RETRY, 0, 0, 0); set_phase(1, K_RETRY, 1, 0, 2); set_phase(2, K_ACK, 0, 0, 0); sc_n = 3;
        run_cmd(1'b1, 32'h8000_0010, 4'hC, 32'h0, 32'hA5A5_0F0F);
        // four retries -> retry fail
        for (int i = 0; i < 4; i++) set_phase(i, K_RETRY, i, 0, 0);
        sc_n = 4;
        run_cmd(1'b0, 32'h8000_0014, 4'h1, 32'h0BAD_CAFE, 32'h0);
        // timeout, plain and with suppression
        set_phase(0, K_NONE, 0, 0, 0); sc_n = 1;
        run_cmd(1'b1, 32'h0000_0020, 4'hF, 32'h0, 32'h1111_1111);
        set_phase(0, K_NONE, 0, 10, 0); sc_n = 1;
        run_cmd(1'b1, 32'h0000_0024, 4'hF, 32'h0, 32'h2222_2222);
        // ack on the very select cycle where the counter would reach the limit
        set_phase(0, K_ACK, 15, 0, 0); sc_n = 1;
        run_cmd(1'b1, 32'h0000_0028, 4'hF, 32'h0, 32'h3333_3333);
        // retry together with xferAck is ignored
        set_phase(0, K_RETRYACK, 0, 0, 0); sc_n = 1;
        run_cmd(1'b1, 32'h0000_002C, 4'hF, 32'h0, 32'h4444_4444);

        reset_mid_xfer();

        for (int n = 0; n < 150; n++) begin
            gen_script();
            run_cmd(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
